// File: rtl/grid_draw_scheduler_if.sv
// Draw-command handshake between the grid scheduler and the LCD command engine.
// The scheduler owns the request and payload; the engine returns a one-cycle ack.
interface grid_draw_scheduler_if;
    logic       draw_req;
    logic [3:0] draw_x;
    logic [3:0] draw_y;
    logic [2:0] draw_code;
    logic       draw_ack;

    modport master (output draw_req, draw_x, draw_y, draw_code, input draw_ack);
    modport slave  (input draw_req, draw_x, draw_y, draw_code, output draw_ack);
endinterface

// File: rtl/grid_draw_scheduler.sv
// Row-major grid scanner that compares each cell against a shadow of the last
// drawn frame and issues one draw command per changed cell.
module grid_draw_scheduler #(
    parameter int         COLS    = 16,
    parameter int         ROWS    = 12,
    parameter logic [2:0] GO_CODE = 3'd7
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       frame_tick,
    input  logic       force_full,
    input  logic       game_over,
    input  logic [2:0] obj_code_in,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       busy,
    output logic       init_cycle,
    output logic       frame_done,
    output logic       overrun,
    grid_draw_scheduler_if.master draw
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [2:0] {START, IDLE, SCAN, REQ, DONE, HALT} state_e;

    state_e     state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [3:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
    logic [2:0] draw_code_q, draw_code_d;
    logic       init_q, init_d, overrun_q, overrun_d;
    logic       pending_q, pending_d, full_q, full_d;
    logic       force_q, force_d, go_q, go_d, go_pending_q, go_pending_d;

    logic [2:0]       shadow [CELLS];
    logic [IDX_W-1:0] idx;
    logic [2:0]       code;
    logic             hit, shadow_we, advance, start_pass, start_go, last_cell;

    assign idx       = IDX_W'(int'(y_q) * COLS + int'(x_q));
    assign code      = go_q ? GO_CODE : obj_code_in;
    assign hit       = full_q || (code != shadow[idx]);
    assign last_cell = (x_q == 4'(COLS - 1)) && (y_q == 4'(ROWS - 1));
    assign busy      = (state_q == SCAN) || (state_q == REQ) || (state_q == DONE);

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        draw_x_d     = draw_x_q;
        draw_y_d     = draw_y_q;
        draw_code_d  = draw_code_q;
        init_d       = init_q;
        overrun_d    = overrun_q;
        pending_d    = pending_q;
        full_d       = full_q;
        force_d      = force_q;
        go_d         = go_q;
        go_pending_d = go_pending_q;
        shadow_we    = 1'b0;
        advance      = 1'b0;
        start_pass   = 1'b0;
        start_go     = 1'b0;

        case (state_q)
            START: start_pass = 1'b1;
            IDLE: begin
                if (game_over)                    start_go   = 1'b1;
                else if (frame_tick || pending_q) start_pass = 1'b1;
            end
            SCAN: begin
                if (hit) begin
                    shadow_we   = 1'b1;
                    draw_x_d    = x_q;
                    draw_y_d    = y_q;
                    draw_code_d = code;
                    state_d     = REQ;
                end else begin
                    advance = 1'b1;
                end
            end
            REQ: advance = draw.draw_ack;
            DONE: begin
                init_d = 1'b0;
                full_d = 1'b0;
                if (go_q)                           state_d    = HALT;
                else if (go_pending_q || game_over) start_go   = 1'b1;
                else if (pending_q)                 start_pass = 1'b1;
                else                                state_d    = IDLE;
            end
            HALT: ;
            default: state_d = START;
        endcase

        if (advance) begin
            state_d = last_cell ? DONE : SCAN;
            if (x_q == 4'(COLS - 1)) begin
                x_d = 4'd0;
                y_d = last_cell ? 4'd0 : y_q + 4'd1;
            end else begin
                x_d = x_q + 4'd1;
            end
        end

        // A new pass latches any queued force request; a mid-pass force waits for the next pass.
        if (start_pass || start_go) begin
            state_d      = SCAN;
            x_d          = 4'd0;
            y_d          = 4'd0;
            full_d       = start_go || force_q || force_full || (state_q == START);
            go_d         = start_go;
            go_pending_d = 1'b0;
            force_d      = 1'b0;
            pending_d    = 1'b0;
        end else if (force_full && state_q != HALT) begin
            force_d = 1'b1;
        end

        if (busy && game_over && !go_q && !start_go) go_pending_d = 1'b1;

        if (busy && frame_tick) begin
            if (pending_q) overrun_d = 1'b1;
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= START;
            x_q          <= '0;
            y_q          <= '0;
            draw_x_q     <= '0;
            draw_y_q     <= '0;
            draw_code_q  <= '0;
            init_q       <= 1'b1;
            overrun_q    <= 1'b0;
            pending_q    <= 1'b0;
            full_q       <= 1'b0;
            force_q      <= 1'b0;
            go_q         <= 1'b0;
            go_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            draw_code_q  <= draw_code_d;
            init_q       <= init_d;
            overrun_q    <= overrun_d;
            pending_q    <= pending_d;
            full_q       <= full_d;
            force_q      <= force_d;
            go_q         <= go_d;
            go_pending_q <= go_pending_d;
        end
    end

    // NOTE: the shadow RAM has no reset; the first pass after reset is always full and rewrites it.
    always_ff @(posedge clk) begin
        if (shadow_we) shadow[idx] <= code;
    end

    assign x              = x_q;
    assign y              = y_q;
    assign init_cycle     = init_q;
    assign overrun        = overrun_q;
    assign frame_done     = (state_q == DONE);
    assign draw.draw_req  = (state_q == REQ);
    assign draw.draw_x    = draw_x_q;
    assign draw.draw_y    = draw_y_q;
    assign draw.draw_code = draw_code_q;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Self-checking bench for grid_draw_scheduler: a map array feeds obj_code_in,
// a randomized ack responder logs requests, and a per-pass model predicts them.
module tb_grid_draw_scheduler;

    localparam int         COLS  = 16;
    localparam int         ROWS  = 12;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [2:0] GO    = 3'd7;
    localparam int         BUDGET = CELLS * 8 + 100;

    logic       clk, nrst, frame_tick, force_full, game_over;
    logic [2:0] obj_code_in;
    logic [3:0] x, y;
    logic       busy, init_cycle, frame_done, overrun;

    grid_draw_scheduler_if dif ();

    grid_draw_scheduler #(.COLS(COLS), .ROWS(ROWS), .GO_CODE(GO)) dut (
        .clk(clk), .nrst(nrst), .frame_tick(frame_tick), .force_full(force_full),
        .game_over(game_over), .obj_code_in(obj_code_in), .x(x), .y(y),
        .busy(busy), .init_cycle(init_cycle), .frame_done(frame_done),
        .overrun(overrun), .draw(dif)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0]  map      [CELLS];
    logic [2:0]  shadow_m [CELLS];
    logic [10:0] exp_q [$];
    logic [10:0] got_q [$];

    bit          ack_en = 0;
    bit          ack_rand = 0;
    int          ack_delay = 3;
    int          stable_errs = 0;
    int          busy_low = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got %0t required < 5ms", $time);
        $fatal(1, "watchdog");
    end

    assign obj_code_in = (int'(y) * COLS + int'(x) < CELLS) ? map[int'(y) * COLS + int'(x)] : 3'd0;

    // LCD engine model: logs each new request, checks payload stability, acks after a delay.
    initial begin
        bit          in_req;
        int          cnt, cur_delay;
        logic [10:0] held;
        in_req = 0; cnt = 0; cur_delay = 0; held = '0;
        dif.draw_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_en || !nrst) begin
                dif.draw_ack = 1'b0;
                in_req = 0;
            end else if (dif.draw_ack) begin
                dif.draw_ack = 1'b0;
            end else if (dif.draw_req) begin
                if (!in_req) begin
                    in_req    = 1;
                    cnt       = 0;
                    held      = {dif.draw_x, dif.draw_y, dif.draw_code};
                    cur_delay = ack_rand ? int'($urandom_range(0, 4)) : ack_delay;
                    got_q.push_back(held);
                end else if ({dif.draw_x, dif.draw_y, dif.draw_code} !== held) begin
                    stable_errs++;
                end
                if (cnt >= cur_delay) begin
                    dif.draw_ack = 1'b1;
                    in_req = 0;
                end else begin
                    cnt++;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    // Expected requests for one pass, from the map, the model shadow and the pass type.
    function automatic void model_pass(input bit full, input bit go);
        logic [2:0] c;
        exp_q.delete();
        for (int i = 0; i < CELLS; i++) begin
            c = go ? GO : map[i];
            if (full || c !== shadow_m[i]) begin
                exp_q.push_back({4'(i % COLS), 4'(i / COLS), c});
                shadow_m[i] = c;
            end
        end
    endfunction

    function automatic int count_diffs();
        int n, d;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    // Optionally pulses frame_tick/force_full, then waits for frame_done.
    task automatic run_pass(input bit do_tick, input bit do_force, output int cycles, output bit ok);
        cycles = 0;
        ok = 0;
        busy_low = 0;
        if (do_tick || do_force) begin
            @(negedge clk);
            frame_tick = do_tick;
            force_full = do_force;
        end
        while (cycles < BUDGET) begin
            @(negedge clk);
            if (cycles == 0) begin
                frame_tick = 0;
                force_full = 0;
            end
            cycles++;
            if (busy !== 1'b1) busy_low++;
            if (frame_done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL pass_timeout: frame_done not seen, got %0d cycles required < %0d", cycles, BUDGET);
        end
    endtask

    task automatic scramble(input int n);
        for (int i = 0; i < n; i++) map[$urandom_range(0, CELLS - 1)] = 3'($urandom_range(0, 6));
    endtask

    task automatic test_reset();
        nrst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, init_cycle, frame_done, overrun, dif.draw_req} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 01000",
                     {busy, init_cycle, frame_done, overrun, dif.draw_req});
        end
        checks++;
        if ({x, y, dif.draw_x, dif.draw_y, dif.draw_code} !== 19'd0) begin
            errors++;
            $display("FAIL reset_coords: got %h required 0", {x, y, dif.draw_x, dif.draw_y, dif.draw_code});
        end
    endtask

    task automatic test_init_pass();
        int cyc; bit ok;
        ack_en = 1; ack_rand = 0; ack_delay = 3;
        got_q.delete();
        model_pass(1, 0);
        nrst = 1;
        run_pass(0, 0, cyc, ok);
        checks++;
        if (count_diffs() !== 0) begin
            errors++;
            $display("FAIL init_requests: got %0d reqs required %0d (diffs %0d)", got_q.size(), exp_q.size(), count_diffs());
        end
        checks++;
        if (got_q.size() !== CELLS || got_q[0] !== 11'h000 || got_q[CELLS-1] !== {4'd15, 4'd11, 3'd0}) begin
            errors++;
            $display("FAIL init_order: got %0d reqs required %0d from (0,0) to (15,11)", got_q.size(), CELLS);
        end
        @(negedge clk);
        checks++;
        if ({init_cycle, busy, dif.draw_req} !== 3'b000) begin
            errors++;
            $display("FAIL init_idle: got %b required 000", {init_cycle, busy, dif.draw_req});
        end
    endtask

    task automatic test_unchanged();
        int cyc; bit ok;
        got_q.delete();
        model_pass(0, 0);
        run_pass(1, 0, cyc, ok);
        checks++;
        if (cyc !== CELLS + 1 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL unchanged_pass: got %0d cycles %0d reqs required %0d cycles 0 reqs", cyc, got_q.size(), CELLS + 1);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL unchanged_busy: got %0d low cycles required 0", busy_low);
        end
    endtask

    task automatic test_single_change();
        int cyc; bit ok;
        map[4 * COLS + 7] = 3'd4;
        ack_delay = 5;
        stable_errs = 0;
        got_q.delete();
        model_pass(0, 0);
        run_pass(1, 0, cyc, ok);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== {4'd7, 4'd4, 3'd4} || count_diffs() !== 0) begin
            errors++;
            $display("FAIL single_change: got %0d reqs first %h required 1 req %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 11'h0, {4'd7, 4'd4, 3'd4});
        end
        checks++;
        if (stable_errs !== 0) begin
            errors++;
            $display("FAIL payload_stable: got %0d changes required 0", stable_errs);
        end
    endtask

    task automatic test_random_passes();
        int cyc; bit ok;
        ack_rand = 1;
        stable_errs = 0;
        for (int p = 0; p < 6; p++) begin
            scramble($urandom_range(0, 12));
            got_q.delete();
            model_pass(p == 2, 0);
            run_pass(1, p == 2, cyc, ok);
            checks++;
            if (count_diffs() !== 0) begin
                errors++;
                $display("FAIL random_pass%0d: got %0d reqs required %0d (diffs %0d)", p, got_q.size(), exp_q.size(), count_diffs());
            end
        end
        checks++;
        if (stable_errs !== 0) begin
            errors++;
            $display("FAIL random_stable: got %0d changes required 0", stable_errs);
        end
    endtask

    task automatic test_force_overrun();
        int cyc; bit ok;
        scramble(6);
        got_q.delete();
        model_pass(0, 0);
        fork
            run_pass(1, 0, cyc, ok);
            begin
                repeat (20) @(negedge clk);
                force_full = 1;
                @(negedge clk);
                force_full = 0;
                frame_tick = 1;
                @(negedge clk);
                frame_tick = 0;
                repeat (3) @(negedge clk);
                frame_tick = 1;
                @(negedge clk);
                frame_tick = 0;
            end
        join
        checks++;
        if (count_diffs() !== 0) begin
            errors++;
            $display("FAIL force_current: got %0d reqs required %0d", got_q.size(), exp_q.size());
        end
        got_q.delete();
        model_pass(1, 0);
        run_pass(0, 0, cyc, ok);
        checks++;
        if (count_diffs() !== 0 || got_q.size() !== CELLS) begin
            errors++;
            $display("FAIL force_next: got %0d reqs required %0d", got_q.size(), CELLS);
        end
        checks++;
        if (busy_low !== 0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_auto: got busy_low %0d overrun %b required 0 and 1", busy_low, overrun);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL force_idle: got busy %b required 0", busy);
        end
    endtask

    task automatic test_game_over();
        int cyc, act; bit ok;
        scramble(5);
        got_q.delete();
        model_pass(0, 0);
        fork
            run_pass(1, 0, cyc, ok);
            begin
                repeat (50) @(negedge clk);
                game_over = 1;
                @(negedge clk);
                game_over = 0;
            end
        join
        checks++;
        if (count_diffs() !== 0) begin
            errors++;
            $display("FAIL go_current: got %0d reqs required %0d", got_q.size(), exp_q.size());
        end
        got_q.delete();
        model_pass(1, 1);
        run_pass(0, 0, cyc, ok);
        checks++;
        if (count_diffs() !== 0 || got_q.size() !== CELLS) begin
            errors++;
            $display("FAIL go_fill: got %0d reqs required %0d code 7", got_q.size(), CELLS);
        end
        act = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            frame_tick = (i == 5);
            force_full = (i == 9);
            if (busy !== 1'b0 || dif.draw_req !== 1'b0 || frame_done !== 1'b0) act++;
        end
        frame_tick = 0;
        force_full = 0;
        checks++;
        if (act !== 0) begin
            errors++;
            $display("FAIL halt_quiet: got %0d active cycles required 0", act);
        end
    endtask

    task automatic test_reset_mid_req();
        int cyc, n; bit ok;
        ack_rand = 0;
        ack_delay = 3;
        for (int i = 0; i < CELLS; i++) map[i] = 3'($urandom_range(0, 6));
        nrst = 0;
        repeat (2) @(negedge clk);
        nrst = 1;
        n = 0;
        while (!(got_q.size() >= 5 && dif.draw_req === 1'b1) && n < 2000) begin
            @(negedge clk);
            if (n == 0) got_q.delete();
            n++;
        end
        nrst = 0;
        @(negedge clk);
        checks++;
        if ({dif.draw_req, busy, init_cycle, x, y} !== {3'b001, 8'h00}) begin
            errors++;
            $display("FAIL reset_in_req: got req %b busy %b init %b x %0d y %0d required 0 0 1 0 0",
                     dif.draw_req, busy, init_cycle, x, y);
        end
        got_q.delete();
        model_pass(1, 0);
        nrst = 1;
        run_pass(0, 0, cyc, ok);
        checks++;
        if (count_diffs() !== 0 || got_q.size() !== CELLS) begin
            errors++;
            $display("FAIL reset_restart: got %0d reqs required %0d", got_q.size(), CELLS);
        end
    endtask

    initial begin
        nrst = 0; frame_tick = 0; force_full = 0; game_over = 0;
        for (int i = 0; i < CELLS; i++) map[i] = 3'd0;
        test_reset();
        test_init_pass();
        test_unchanged();
        test_single_change();
        test_random_passes();
        test_force_overrun();
        test_game_over();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
